// File: rtl/sipo_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sipo_receiver: strobed serial-to-parallel word receiver, valid/ready output |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sipo_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_i,
  input  logic             sin_valid_i,
  input  logic             sin_start_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             busy_o,
  output logic             framing_err_o,
  output logic             overrun_o
);

  localparam int              c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;

  logic                 w_accept;
  logic                 w_dir;
  logic                 w_load;
  logic [WIDTH-1:0]     w_shifted;

  // A start bit is taken in any state; plain bits only extend a word in progress.
  assign w_accept  = sin_valid_i && (sin_start_i || (state_q == SHIFT));
  assign w_dir     = sin_start_i ? dir_i : dir_q;
  assign w_load    = !dout_valid_q || dout_ready_i;
  assign w_shifted = w_dir ? {sin_i, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], sin_i};

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    framing_err_d = 1'b0;
    overrun_d     = 1'b0;

    if (dout_valid_q && dout_ready_i) begin
      dout_valid_d = 1'b0;
    end

    if (w_accept) begin
      sr_d = w_shifted;
      if (sin_start_i) begin
        dir_d         = dir_i;
        cnt_d         = c_ONE;
        state_d       = SHIFT;
        framing_err_d = (state_q == SHIFT);
      end else if (cnt_q == c_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        if (w_load) begin
          dout_d       = w_shifted;
          dout_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + c_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign dout_o        = dout_q;
  assign dout_valid_o  = dout_valid_q;
  assign busy_o        = (state_q == SHIFT);
  assign framing_err_o = framing_err_q;
  assign overrun_o     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sipo_receiver: scoreboard bench for sipo_receiver (WIDTH=8)              |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_sipo_receiver;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sin_start = 1'b0;
  logic         dir = 1'b0;
  logic         dout_ready = 1'b1;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         busy;
  logic         framing_err;
  logic         overrun;

  int n_cmp = 0;
  int n_fail = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int fe_exp = 0;
  int ov_exp = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_receiver #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sin_i        (sin),
    .sin_valid_i  (sin_valid),
    .sin_start_i  (sin_start),
    .dir_i        (dir),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .busy_o       (busy),
    .framing_err_o(framing_err),
    .overrun_o    (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed word is checked against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", dout, $time);
        end else begin
          chk("dout_word", dout, exp_q.pop_front());
        end
      end
      if (framing_err) fe_seen++;
      if (overrun) ov_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st, input logic d);
    sin       = b;
    sin_valid = 1'b1;
    sin_start = st;
    dir       = st ? d : 1'($urandom);
    tick();
    sin_valid = 1'b0;
    sin_start = 1'b0;
    sin       = 1'($urandom);
    dir       = 1'($urandom);
  endtask

  // Transmit bits lo..hi-1 of word w in line order; position 0 carries the start mark.
  task automatic send_bits(input logic [W-1:0] w, input logic d, input int lo, input int hi,
                           input int gapmax);
    int g;
    for (int i = lo; i < hi; i++) begin
      g = (i == 0) ? 0 : int'($urandom_range(0, gapmax));
      repeat (g) tick();
      send_bit(d ? w[i] : w[W-1-i], (i == 0), d);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    logic         d;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", framing_err, 0);
    chk("rst_ov", overrun, 0);
    rst_n = 1'b1;
    tick();

    // MSB-first
    exp_q.push_back(8'h1E);
    send_bits(8'h1E, 1'b0, 0, 7, 0);
    chk("t1_busy_mid", busy, 1);
    send_bits(8'h1E, 1'b0, 7, 8, 0);
    chk("t1_valid", dout_valid, 1);
    chk("t1_dout", dout, 8'h1E);
    chk("t1_busy", busy, 0);
    tick();

    // LSB-first, same line sequence
    exp_q.push_back(8'h78);
    send_bits(8'h78, 1'b1, 0, 8, 0);
    chk("t2_dout", dout, 8'h78);
    tick();

    // Backpressure: second word is dropped
    dout_ready = 1'b0;
    exp_q.push_back(8'h1E);
    send_bits(8'h1E, 1'b0, 0, 8, 0);
    chk("t3_valid1", dout_valid, 1);
    send_bits(8'hC3, 1'b0, 0, 8, 0);
    ov_exp++;
    chk("t3_overrun", overrun, 1);
    chk("t3_dout_held", dout, 8'h1E);
    tick();
    chk("t3_overrun_pulse", overrun, 0);
    chk("t3_valid_held", dout_valid, 1);
    dout_ready = 1'b1;
    tick();
    chk("t3_valid_drop", dout_valid, 0);

    // Restart mid-word
    send_bits(8'h33, 1'b0, 0, 5, 0);
    chk("t4_busy", busy, 1);
    exp_q.push_back(8'hA7);
    send_bits(8'hA7, 1'b0, 0, 1, 0);
    fe_exp++;
    chk("t4_fe", framing_err, 1);
    send_bits(8'hA7, 1'b0, 1, 8, 0);
    chk("t4_fe_pulse", framing_err, 0);
    chk("t4_dout", dout, 8'hA7);
    tick();

    // Stray bits in IDLE, then a gappy word
    repeat (3) send_bit(1'($urandom), 1'b0, 1'($urandom));
    chk("t5_stray_busy", busy, 0);
    chk("t5_stray_valid", dout_valid, 0);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 1'b0, 0, 8, 3);
    chk("t5_dout", dout, 8'h5A);
    tick();

    // Asynchronous reset mid-word
    send_bits(8'h3C, 1'b0, 0, 4, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_dout", dout, 0);
    chk("t6_valid", dout_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fe", framing_err, 0);
    chk("t6_ov", overrun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8'h81);
    send_bits(8'h81, 1'b0, 0, 8, 0);
    chk("t6_dout_after", dout, 8'h81);
    tick();

    // Randomized traffic with occasional aborts and stray bits
    for (int k = 0; k < 24; k++) begin
      w = 8'($urandom);
      d = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_bits(8'($urandom), 1'($urandom), 0, int'($urandom_range(1, 7)), 1);
        fe_exp++;
      end
      exp_q.push_back(w);
      send_bits(w, d, 0, 8, 2);
      if ($urandom_range(0, 2) == 0) send_bit(1'($urandom), 1'b0, 1'($urandom));
    end

    repeat (4) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("fe_count", fe_seen, fe_exp);
    chk("ov_count", ov_seen, ov_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
